// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce.
// Drives one active-low column at a time, watches the synchronized rows,
// debounces presses and releases over whole scan ticks and emits one
// user_latch pulse per accepted key together with its code.
// Optional build macro KEYPAD_DIGITS_ONLY_EN: keys A-F are still tracked
// through press/release (key_held) but never latch or update user_digit.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] user_digit,
    output logic       user_latch,
    output logic       key_held
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [3:0]    row_meta, row_sync;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [1:0]    col_idx, col_idx_n;
    logic [1:0]    row_idx, row_idx_n;
    logic [1:0]    low_idx;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic          any_low, sel_low;
    logic [3:0]    code;
    logic          accept;
    logic          latch_n;

    // Row lookup table: (row, col) -> key code.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = 4'h0;
        case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            4'hF: k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    // Two-flop synchronizer; idle rows are pulled up, so clear to all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Free-running scan-tick divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Lowest-numbered low row wins when several are pressed at capture.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_sync[i]) low_idx = 2'(i);
        end
    end

    assign any_low = ~&row_sync;
    assign sel_low = ~row_sync[row_idx];
    assign cnt_inc = (cnt == CNT_DONE) ? cnt : cnt + CW'(1);
    assign code    = key_code(row_idx, col_idx);

`ifdef KEYPAD_DIGITS_ONLY_EN
    assign accept = (code < 4'hA);
`else
    assign accept = 1'b1;
`endif

    // State, frozen column/row indices and debounce count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SCAN;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            col_idx <= col_idx_n;
            row_idx <= row_idx_n;
            cnt     <= cnt_n;
        end
    end

    // Next-state logic; all decisions happen only on scan ticks.
    always_comb begin
        state_n   = state;
        col_idx_n = col_idx;
        row_idx_n = row_idx;
        cnt_n     = cnt;
        latch_n   = 1'b0;
        case (state)
            SCAN: begin
                if (tick) begin
                    if (any_low) begin
                        row_idx_n = low_idx;
                        cnt_n     = '0;
                        state_n   = DEBOUNCE;
                    end else begin
                        col_idx_n = col_idx + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (sel_low) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_n = PRESSED;
                            latch_n = accept;
                        end
                    end else begin
                        // Bounce: column resumes from where it froze.
                        state_n = SCAN;
                    end
                end
            end
            PRESSED: begin
                if (tick && !any_low) begin
                    cnt_n   = '0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (tick) begin
                    if (any_low) begin
                        cnt_n   = '0;
                        state_n = PRESSED;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_DONE) state_n = SCAN;
                    end
                end
            end
            default: state_n = SCAN;
        endcase
    end

    // Latch pulse and held key code, registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            user_latch <= 1'b0;
            user_digit <= 4'h0;
        end else begin
            user_latch <= latch_n;
            if (latch_n) user_digit <= code;
        end
    end

    assign col      = ~(4'b0001 << col_idx);
    assign key_held = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench with a 4x4 key-matrix model.
// Pressed keys pull their row low only while their column is driven low.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  user_digit;
    logic        user_latch;
    logic        key_held;
    logic [15:0] key_dn = '0;   // bit r*4+c

    int cyc = 0;
    int t0 = 0;
    int latch_cnt = 0;
    int base = 0;
    int n_chk = 0;
    int n_bad = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .user_digit (user_digit),
        .user_latch (user_latch),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (user_latch) latch_cnt <= latch_cnt + 1;

    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            row[r] = ~|(key_dn[r*4 +: 4] & ~col);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc - t0);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc - t0 < n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] keys);
        @(negedge clk);
        reset  = 1'b0;
        key_dn = keys;
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(col), 32'hE);
        chk("rst_dig", 32'(user_digit), 32'h0);
        chk("rst_latch", 32'(user_latch), 32'h0);
        chk("rst_held", 32'(key_held), 32'h0);
        reset = 1'b1;
        t0    = cyc;
        base  = latch_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Idle scan, no key.
        do_reset(16'h0);
        wait_cyc(0);  chk("idle_c0", 32'(col), 32'hE);
        wait_cyc(3);  chk("idle_c3", 32'(col), 32'hE);
        wait_cyc(4);  chk("idle_c4", 32'(col), 32'hD);
        wait_cyc(8);  chk("idle_c8", 32'(col), 32'hB);
        wait_cyc(12); chk("idle_c12", 32'(col), 32'h7);
        wait_cyc(16); chk("idle_c16", 32'(col), 32'hE);
        wait_cyc(20); chk("idle_nolatch", 32'(latch_cnt - base), 32'd0);

        // Key (1,1) = 5: capture at tick 8, latch after tick 20.
        do_reset(16'h1 << 5);
        wait_cyc(19); chk("k5_pre", 32'(user_latch), 32'h0);
        wait_cyc(20); chk("k5_latch", 32'(user_latch), 32'h1);
                      chk("k5_dig", 32'(user_digit), 32'h5);
                      chk("k5_held", 32'(key_held), 32'h1);
        wait_cyc(21); chk("k5_pulse", 32'(user_latch), 32'h0);
        wait_cyc(40); chk("k5_dig_hold", 32'(user_digit), 32'h5);
                      chk("k5_col_frz", 32'(col), 32'hD);
        wait_cyc(45); key_dn = '0;
        wait_cyc(59); chk("k5_rel59", 32'(key_held), 32'h1);
        wait_cyc(60); chk("k5_rel60", 32'(key_held), 32'h0);
                      chk("k5_one", 32'(latch_cnt - base), 32'd1);
        wait_cyc(63); chk("k5_col63", 32'(col), 32'hD);
        wait_cyc(64); chk("k5_col64", 32'(col), 32'hB);

        // Key (0,0) bounce: seen on only 2 ticks.
        do_reset(16'h1);
        wait_cyc(8);  chk("bnc_frz", 32'(col), 32'hE);
        wait_cyc(9);  key_dn = '0;
        wait_cyc(12); chk("bnc_held", 32'(key_held), 32'h0);
        wait_cyc(15); chk("bnc_c15", 32'(col), 32'hE);
        wait_cyc(16); chk("bnc_c16", 32'(col), 32'hD);
        wait_cyc(24); chk("bnc_nolatch", 32'(latch_cnt - base), 32'd0);

        // Key (3,2) = F held, then (0,2) added: ignored.
        do_reset(16'h1 << 14);
        wait_cyc(24); chk("kf_latch", 32'(user_latch), 32'h1);
                      chk("kf_dig", 32'(user_digit), 32'hF);
        wait_cyc(30); key_dn = (16'h1 << 14) | (16'h1 << 2);
        wait_cyc(60); chk("kf_one", 32'(latch_cnt - base), 32'd1);
                      chk("kf_held", 32'(key_held), 32'h1);
                      chk("kf_dig2", 32'(user_digit), 32'hF);
                      key_dn = '0;
        wait_cyc(75); chk("kf_rel75", 32'(key_held), 32'h1);
        wait_cyc(76); chk("kf_rel76", 32'(key_held), 32'h0);
                      chk("kf_one2", 32'(latch_cnt - base), 32'd1);

        // Simultaneous (0,2)=3 and (3,2)=F: lowest row wins.
        do_reset((16'h1 << 14) | (16'h1 << 2));
        wait_cyc(24); chk("pri_latch", 32'(user_latch), 32'h1);
                      chk("pri_dig", 32'(user_digit), 32'h3);

        // Reset in DEBOUNCE aborts; held key re-debounces afterwards.
        do_reset(16'h1 << 5);
        wait_cyc(13); reset = 1'b0;
        @(negedge clk);
        chk("abort_col", 32'(col), 32'hE);
        chk("abort_held", 32'(key_held), 32'h0);
        chk("abort_nolatch", 32'(latch_cnt - base), 32'd0);
        do_reset(16'h1 << 5);
        wait_cyc(19); chk("re_pre", 32'(user_latch), 32'h0);
        wait_cyc(20); chk("re_latch", 32'(user_latch), 32'h1);
                      chk("re_dig", 32'(user_digit), 32'h5);
        wait_cyc(24); chk("re_one", 32'(latch_cnt - base), 32'd1);

        // Letter key (0,3) = A.
        do_reset(16'h1 << 3);
`ifdef KEYPAD_DIGITS_ONLY_EN
        wait_cyc(28); chk("ka_latch", 32'(user_latch), 32'h0);
                      chk("ka_dig", 32'(user_digit), 32'h0);
                      chk("ka_held", 32'(key_held), 32'h1);
`else
        wait_cyc(28); chk("ka_latch", 32'(user_latch), 32'h1);
                      chk("ka_dig", 32'(user_digit), 32'hA);
                      chk("ka_held", 32'(key_held), 32'h1);
`endif
        wait_cyc(30); key_dn = '0;
        wait_cyc(47); chk("ka_rel47", 32'(key_held), 32'h1);
        wait_cyc(48); chk("ka_rel48", 32'(key_held), 32'h0);
`ifdef KEYPAD_DIGITS_ONLY_EN
        chk("ka_cnt", 32'(latch_cnt - base), 32'd0);
`else
        chk("ka_cnt", 32'(latch_cnt - base), 32'd1);
`endif

        // Key (3,1) = 0 (a digit in every build).
        do_reset(16'h1 << 13);
        wait_cyc(20); chk("k0_latch", 32'(user_latch), 32'h1);
                      chk("k0_dig", 32'(user_digit), 32'h0);
                      chk("k0_held", 32'(key_held), 32'h1);
        wait_cyc(24); chk("k0_one", 32'(latch_cnt - base), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50_000, is the number of clk cycles per scan tick (1 ms at 50 MHz).
REQ-002 Parameter DEBOUNCE_SCANS, default 20, is the number of consecutive stable scan ticks needed to accept a press or a release.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 row  input  4  keypad row sense, active-low, externally pulled up, asynchronous to clk.
REQ-006 col  output  4  keypad column drive, active-low, exactly one bit low outside reset.
REQ-007 user_digit  output  4  code of the accepted key, stable from the user_latch cycle until the next accepted key.
REQ-008 user_latch  output  1  single-cycle pulse per accepted key press; feeds the OTP-entry FSM.
REQ-009 key_held  output  1  high while an accepted key is considered pressed.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 A tick counter SHALL count 0..SCAN_DIV-1 and wrap; tick is the cycle the counter equals SCAN_DIV-1.
REQ-012 States: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-013 SCAN: on each tick with no synchronized row low, the active column SHALL advance 0->1->2->3->0; col = ~(4'b0001 << idx).
REQ-014 SCAN: on a tick with any synchronized row low, the block SHALL capture the row index (lowest index wins if several are low) and the column index, freeze the column, clear the stable count and enter DEBOUNCE.
REQ-015 DEBOUNCE: on each tick with the captured row still low, the stable count SHALL increment; when it reaches DEBOUNCE_SCANS, the block SHALL enter PRESSED and pulse user_latch in the cycle after that tick.
REQ-016 DEBOUNCE: on a tick with the captured row high, the block SHALL return to SCAN with no latch; the column SHALL resume advancing from the frozen index on the next tick.
REQ-017 PRESSED: key_held=1, column frozen; on the first tick with all rows high, the block SHALL clear the count and enter RELEASE.
REQ-018 RELEASE: each tick with all rows high SHALL increment the count; on reaching DEBOUNCE_SCANS the block SHALL enter SCAN and key_held SHALL drop; any row low resets the count and returns to PRESSED with no new latch.
REQ-019 Key map (row,col) -> code: row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 E(*),0,F(#),D.
REQ-020 user_digit SHALL be updated in the same cycle user_latch is high.
REQ-021 Holding a key SHALL produce exactly one latch; a second key pressed while one is held SHALL be ignored.
REQ-022 The count SHALL saturate and not wrap; its width SHALL be $clog2(DEBOUNCE_SCANS+1).

Reset
REQ-023 While reset=0: state=SCAN, col=4'b1110, user_digit=0, user_latch=0, key_held=0, all counters and synchronizers cleared (synchronizer to 4'b1111).
REQ-024 Reset asserted mid-debounce or mid-press SHALL abort without a latch; after release, a still-held key SHALL be re-debounced from SCAN.

Configuration
REQ-025 Macro KEYPAD_DIGITS_ONLY_EN defined: keys with code A-F SHALL complete the debounce/press/release sequence, with key_held asserted, but SHALL NOT pulse user_latch or update user_digit.
REQ-026 Macro KEYPAD_DIGITS_ONLY_EN undefined: all 16 keys SHALL latch per REQ-019.

Verification
REQ-027 Bench uses SCAN_DIV=4 and DEBOUNCE_SCANS=3.
REQ-028 Reset release, no key pressed -> col cycles 1110,1101,1011,0111 every 4 clk; user_latch never high.
REQ-029 row1 low while col=1101, held 10 ticks -> exactly one user_latch with user_digit=5; key_held high until 3 release ticks after row goes high.
REQ-030 row0 low for only 2 ticks at col=1110 -> no latch; scanning resumes.
REQ-031 row3 held at col=1011, then row0 also driven low -> single latch with user_digit=F; no second latch.
REQ-032 Reset asserted during DEBOUNCE -> no latch, col=1110; after reset is deasserted, the held key latches once after 3 stable ticks.
REQ-033 KEYPAD_DIGITS_ONLY_EN defined, press row0/col3 -> key_held pulses, no user_latch; then press row3/col1 -> user_latch with user_digit=0.
